// File: rtl/ufi_ram_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : ufi_ram_write_arbiter
// Purpose : Round-robin, burst-locked sharing of one RAM write port among Ufi
//           write masters, through a 1-deep registered stage with backpressure.
// Rev     : 1.0
// ============================================================================
module ufi_ram_write_arbiter #(
    parameter int pMasterNum    = 2,
    parameter int pDataWidth    = 32,
    parameter int pRamAdrsWidth = 16,
    parameter int pTimeoutCycle = 1024
) (
    input  logic                             iSCLK,
    input  logic                             iSRST,
    input  logic [pMasterNum*pDataWidth-1:0] iMUfiWd,
    input  logic [pMasterNum*32-1:0]         iMUfiAdrs,
    input  logic [pMasterNum-1:0]            iMUfiWEd,
    input  logic [pMasterNum-1:0]            iMUfiWVd,
    output logic [pMasterNum-1:0]            oMUfiGnt,
    output logic [pMasterNum-1:0]            oMUfiWRdy,
    output logic [pDataWidth-1:0]            oRamWd,
    output logic [pRamAdrsWidth-1:0]         oRamAdrs,
    output logic                             oRamWe,
    input  logic                             iRamWRdy,
    output logic                             oAdrsErr,
    output logic                             oProtoErr,
    output logic                             oTimeoutIntr,
    input  logic                             iErrClr
);
    localparam int c_IDX_W  = (pMasterNum > 1) ? $clog2(pMasterNum) : 1;
    localparam int c_TCNT_W = (pTimeoutCycle > 1) ? $clog2(pTimeoutCycle) : 1;
    localparam logic [c_IDX_W-1:0]  c_LAST_IDX = c_IDX_W'(pMasterNum - 1);
    localparam logic [c_TCNT_W-1:0] c_TCNT_MAX = c_TCNT_W'(pTimeoutCycle - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                r_state;
    logic [c_IDX_W-1:0]    r_owner;
    logic [c_IDX_W-1:0]    r_rr_ptr;
    logic [c_TCNT_W-1:0]   r_tcnt;
    logic [c_IDX_W-1:0]    w_win;
    logic                  w_win_vld;
    logic [pDataWidth-1:0] w_own_wd;
    logic [31:0]           w_own_adrs;
    logic                  w_own_wed;
    logic                  w_own_wvd;
    logic                  w_own_rdy;
    logic                  w_accept;
    logic                  w_adrs_bad;
    logic                  w_load;
    logic                  w_proto;

    // Scan offsets from the highest down so the requester nearest the pointer wins.
    always_comb begin
        int j;
        j         = 0;
        w_win     = r_rr_ptr;
        w_win_vld = 1'b0;
        for (int k = pMasterNum - 1; k >= 0; k--) begin
            j = (int'(r_rr_ptr) + k) % pMasterNum;
            if (iMUfiWVd[j]) begin
                w_win     = c_IDX_W'(j);
                w_win_vld = 1'b1;
            end
        end
    end

    assign w_own_wd   = iMUfiWd[int'(r_owner)*pDataWidth +: pDataWidth];
    assign w_own_adrs = iMUfiAdrs[int'(r_owner)*32 +: 32];
    assign w_own_wed  = (r_state == ST_GRANT) & iMUfiWEd[r_owner];
    assign w_own_wvd  = iMUfiWVd[r_owner];
    assign oMUfiWRdy  = oMUfiGnt & {pMasterNum{~oRamWe | iRamWRdy}};
    assign w_own_rdy  = oMUfiWRdy[r_owner];
    assign w_accept   = w_own_wed & w_own_rdy;
    assign w_adrs_bad = (w_own_adrs >> pRamAdrsWidth) != 32'd0;
    assign w_load     = w_accept & ~w_adrs_bad;
    assign w_proto    = w_own_wed & ~w_own_rdy;

    always_ff @(posedge iSCLK or negedge iSRST) begin
        if (!iSRST) begin
            r_state      <= ST_IDLE;
            r_owner      <= '0;
            r_rr_ptr     <= '0;
            r_tcnt       <= '0;
            oMUfiGnt     <= '0;
            oRamWd       <= '0;
            oRamAdrs     <= '0;
            oRamWe       <= 1'b0;
            oAdrsErr     <= 1'b0;
            oProtoErr    <= 1'b0;
            oTimeoutIntr <= 1'b0;
        end else begin
            oTimeoutIntr <= 1'b0;

            // A dropped (out-of-range) word still completes its handshake.
            if (w_load) begin
                oRamWe   <= 1'b1;
                oRamWd   <= w_own_wd;
                oRamAdrs <= w_own_adrs[pRamAdrsWidth-1:0];
            end else if (iRamWRdy) begin
                oRamWe <= 1'b0;
            end

            if (w_accept & w_adrs_bad) begin
                oAdrsErr <= 1'b1;
            end else if (iErrClr) begin
                oAdrsErr <= 1'b0;
            end

            if (w_proto) begin
                oProtoErr <= 1'b1;
            end else if (iErrClr) begin
                oProtoErr <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_win_vld) begin
                        r_state  <= ST_GRANT;
                        r_owner  <= w_win;
                        oMUfiGnt <= pMasterNum'(1) << w_win;
                        r_tcnt   <= '0;
                    end
                end
                ST_GRANT: begin
                    if (!w_own_wvd) begin
                        r_state  <= ST_DRAIN;
                        oMUfiGnt <= '0;
                    end else if (w_accept) begin
                        r_tcnt <= '0;
                    end else if (r_tcnt == c_TCNT_MAX) begin
                        r_state      <= ST_DRAIN;
                        oMUfiGnt     <= '0;
                        oTimeoutIntr <= 1'b1;
                    end else begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (!oRamWe) begin
                        r_state  <= ST_IDLE;
                        r_tcnt   <= '0;
                        r_rr_ptr <= (r_owner == c_LAST_IDX) ? '0 : r_owner + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_ufi_ram_write_arbiter.sv
`default_nettype none
// Bench for ufi_ram_write_arbiter: per-cycle vector table plus hand sequences;
// words reaching the RAM side are compared against a scoreboard queue.
module tb_ufi_ram_write_arbiter;
    localparam int NM = 2;
    localparam int DW = 32;
    localparam int AW = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NM*DW-1:0]  wd;
    logic [NM*32-1:0]  adrs;
    logic [NM-1:0]     wed, wvd, gnt, wrdy;
    logic [DW-1:0]     ram_wd;
    logic [AW-1:0]     ram_adrs;
    logic              ram_we, ram_rdy, adrs_err, proto_err, tintr, err_clr;

    int checks = 0;
    int errors = 0;
    int accepted = 0;
    logic [AW+DW-1:0] sb_q[$];
    logic [AW+DW-1:0] exp_word;

    typedef struct {
        logic [NM-1:0] wvd;
        logic [NM-1:0] wed;
        logic [31:0]   a;
        logic [NM-1:0] egnt;
        logic [NM-1:0] ewrdy;
        logic          ewe;
    } vec_t;
    vec_t tbl[16];

    always #5 clk = ~clk;

    ufi_ram_write_arbiter #(
        .pMasterNum(NM), .pDataWidth(DW), .pRamAdrsWidth(AW), .pTimeoutCycle(1024)
    ) dut (
        .iSCLK(clk), .iSRST(rst_n), .iMUfiWd(wd), .iMUfiAdrs(adrs),
        .iMUfiWEd(wed), .iMUfiWVd(wvd), .oMUfiGnt(gnt), .oMUfiWRdy(wrdy),
        .oRamWd(ram_wd), .oRamAdrs(ram_adrs), .oRamWe(ram_we), .iRamWRdy(ram_rdy),
        .oAdrsErr(adrs_err), .oProtoErr(proto_err), .oTimeoutIntr(tintr), .iErrClr(err_clr)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Every word the RAM accepts must be the oldest outstanding expected word.
    always @(negedge clk) begin
        if (rst_n && ram_we && ram_rdy) begin
            accepted++;
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL ram_word: got %0h/%0h expected no word", ram_adrs, ram_wd);
            end else begin
                exp_word = sb_q.pop_front();
                if ({ram_adrs, ram_wd} !== exp_word) begin
                    errors++;
                    $display("FAIL ram_word: got %0h expected %0h", {ram_adrs, ram_wd}, exp_word);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion expected finish within 2ms");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_word(input int m, input logic [31:0] a, input logic [DW-1:0] d);
        for (int i = 0; i < NM; i++) begin
            adrs[i*32 +: 32] = (i == m) ? a : (a ^ 32'h5A);
            wd[i*DW +: DW]   = (i == m) ? d : ~d;
        end
    endtask

    task automatic push_word(input logic [31:0] a, input logic [DW-1:0] d);
        logic [AW-1:0] aw;
        aw = a[AW-1:0];
        sb_q.push_back({aw, d});
    endtask

    task automatic do_reset();
        rst_n = 1'b0; wvd = '0; wed = '0; ram_rdy = 1'b1; err_clr = 1'b0; wd = '0; adrs = '0;
        sb_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic setv(input int i, input logic [1:0] wv, input logic [1:0] we,
                        input logic [31:0] a, input logic [1:0] g, input logic [1:0] r,
                        input logic e);
        tbl[i].wvd = wv; tbl[i].wed = we; tbl[i].a = a;
        tbl[i].egnt = g; tbl[i].ewrdy = r; tbl[i].ewe = e;
    endtask

    // Master m streams n words; RAM stalls for stall_len cycles from stall_at.
    task automatic burst(input int m, input logic [31:0] base, input int n,
                         input int stall_at, input int stall_len);
        int i = 0;
        int cyc = 0;
        logic [DW-1:0] d;
        while (i < n && cyc < n + stall_len + 10) begin
            ram_rdy = !(cyc >= stall_at && cyc < stall_at + stall_len);
            d = (base + i) ^ 32'hBEEF_0000;
            drive_word(m, base + i, d);
            #1;
            wed = wrdy[m] ? (NM'(1) << m) : '0;
            if (wed != '0) push_word(base + i, d);
            @(negedge clk);
            if (!ram_rdy && ram_we) begin
                chk("stall_wrdy", wrdy[m], 1'b0);
                if (sb_q.size() > 0) chk("stall_hold", {ram_adrs, ram_wd}, sb_q[0]);
            end
            @(posedge clk);
            #1;
            if (wed != '0) i++;
            cyc++;
        end
        wed = '0;
        ram_rdy = 1'b1;
        chk("burst_done", i, n);
    endtask

    task automatic wait_gnt(input logic [NM-1:0] exp, input int budget, input string name);
        int n = 0;
        while (gnt !== exp && n < budget) begin
            step();
            n++;
        end
        chk(name, gnt, exp);
    endtask

    initial begin
        int acc0;
        int n_to;
        //   idx wvd    wed    adrs        gnt    wrdy   we
        setv(0,  2'b00, 2'b00, 32'h0,     2'b00, 2'b00, 1'b0);
        setv(1,  2'b01, 2'b00, 32'h0,     2'b00, 2'b00, 1'b0);
        setv(2,  2'b01, 2'b01, 32'h100,   2'b01, 2'b01, 1'b0);
        setv(3,  2'b01, 2'b01, 32'h101,   2'b01, 2'b01, 1'b1);
        setv(4,  2'b01, 2'b01, 32'h102,   2'b01, 2'b01, 1'b1);
        setv(5,  2'b01, 2'b01, 32'h103,   2'b01, 2'b01, 1'b1);
        setv(6,  2'b00, 2'b00, 32'h0,     2'b01, 2'b01, 1'b1);
        setv(7,  2'b00, 2'b00, 32'h0,     2'b00, 2'b00, 1'b0);
        setv(8,  2'b11, 2'b00, 32'h0,     2'b00, 2'b00, 1'b0);
        setv(9,  2'b11, 2'b10, 32'h200,   2'b10, 2'b10, 1'b0);
        setv(10, 2'b01, 2'b00, 32'h0,     2'b10, 2'b10, 1'b1);
        setv(11, 2'b01, 2'b00, 32'h0,     2'b00, 2'b00, 1'b0);
        setv(12, 2'b01, 2'b00, 32'h0,     2'b00, 2'b00, 1'b0);
        setv(13, 2'b01, 2'b10, 32'h300,   2'b01, 2'b01, 1'b0);
        setv(14, 2'b00, 2'b00, 32'h0,     2'b01, 2'b01, 1'b0);
        setv(15, 2'b00, 2'b00, 32'h0,     2'b00, 2'b00, 1'b0);

        wvd = '0; wed = '0; ram_rdy = 1'b1; err_clr = 1'b0; wd = '0; adrs = '0;
        @(negedge clk);
        chk("reset_gnt", gnt, 0);
        chk("reset_we", ram_we, 0);
        chk("reset_flags", {adrs_err, proto_err, tintr}, 0);
        do_reset();

        // Single M0 burst, round robin to M1, then non-owner WEd ignored.
        for (int v = 0; v < 16; v++) begin
            int m;
            logic [DW-1:0] d;
            m = tbl[v].wed[1] ? 1 : 0;
            d = tbl[v].a ^ 32'hC0DE_0000;
            wvd = tbl[v].wvd;
            drive_word(m, tbl[v].a, d);
            wed = tbl[v].wed;
            if ((tbl[v].wed & tbl[v].ewrdy) != '0) push_word(tbl[v].a, d);
            @(negedge clk);
            chk($sformatf("v%0d_gnt", v), gnt, tbl[v].egnt);
            chk($sformatf("v%0d_wrdy", v), wrdy, tbl[v].ewrdy);
            chk($sformatf("v%0d_we", v), ram_we, tbl[v].ewe);
            chk($sformatf("v%0d_errs", v), {adrs_err, proto_err}, 0);
            step();
        end
        chk("table_sb_empty", sb_q.size(), 0);

        // Simultaneous requests from pointer 0, then round robin.
        do_reset();
        wvd = 2'b11;
        step();
        chk("rr_first_m0", gnt, 2'b01);
        burst(0, 32'h700, 2, 0, 0);
        wvd = 2'b00;
        repeat (3) step();
        chk("dropped_req_not_served", gnt, 2'b00);
        wvd = 2'b11;
        step();
        chk("rr_second_m1", gnt, 2'b10);
        wvd = 2'b01;
        wait_gnt(2'b01, 6, "rr_back_to_m0");
        wvd = 2'b00;
        repeat (3) step();

        // RAM backpressure mid-burst.
        do_reset();
        acc0 = accepted;
        wvd = 2'b01;
        step();
        chk("bp_gnt", gnt, 2'b01);
        burst(0, 32'h400, 8, 3, 5);
        wvd = 2'b00;
        repeat (3) step();
        chk("bp_words_accepted", accepted - acc0, 8);
        chk("bp_sb_empty", sb_q.size(), 0);

        // Address range and protocol errors.
        do_reset();
        wvd = 2'b01;
        step();
        drive_word(0, 32'h0001_0000, 32'h1111_2222);
        wed = 2'b01;
        step();
        wed = 2'b00;
        @(negedge clk);
        chk("adrs_err_no_we", ram_we, 0);
        chk("adrs_err_set", adrs_err, 1);
        step();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("adrs_err_clr", adrs_err, 0);
        drive_word(0, 32'h500, 32'h5555_0500);
        wed = 2'b01;
        push_word(32'h500, 32'h5555_0500);
        step();
        ram_rdy = 1'b0;
        drive_word(0, 32'h501, 32'h5555_0501);
        step();
        wed = 2'b00;
        @(negedge clk);
        chk("proto_err_set", proto_err, 1);
        chk("proto_hold_adrs", ram_adrs, 16'h0500);
        step();
        ram_rdy = 1'b1;
        step();
        drive_word(0, 32'h0002_0000, 32'h0);
        wed = 2'b01;
        err_clr = 1'b1;
        step();
        wed = 2'b00;
        err_clr = 1'b0;
        chk("set_wins_adrs_err", adrs_err, 1);
        chk("clr_proto_err", proto_err, 0);
        chk("err_sb_empty", sb_q.size(), 0);
        wvd = 2'b00;
        repeat (3) step();

        // Idle timeout on M0 with M1 pending, then reset mid-burst.
        do_reset();
        wvd = 2'b11;
        n_to = 0;
        while (n_to < 1100 && !tintr) begin
            step();
            n_to++;
        end
        chk("timeout_latency", n_to, 1025);
        chk("timeout_gnt_released", gnt, 2'b00);
        step();
        chk("timeout_pulse_width", tintr, 0);
        step();
        chk("timeout_next_owner", gnt, 2'b10);
        drive_word(1, 32'h600, 32'h6666_0600);
        wed = 2'b10;
        ram_rdy = 1'b0;
        step();
        wed = 2'b00;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_gnt_wrdy", {gnt, wrdy}, 0);
        chk("arst_ram", {ram_we, ram_adrs, ram_wd}, 0);
        chk("arst_flags", {adrs_err, proto_err, tintr}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ram_rdy = 1'b1;
        step();
        chk("arst_rr_ptr0", gnt, 2'b01);
        wvd = 2'b00;
        repeat (3) step();
        chk("final_sb_empty", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
